button_debouncer: RTL

//  Conditions a raw, bouncing, asynchronous push-button input for the button counter stage.
//  - Synchronises the input into clk.
//  - Filters contact bounce with a stability counter.
//  - Emits single-cycle press/release strobes plus a debounced level.
//  - Optional auto-repeat: while the button is held, further press strobes are generated.

---
 rtl/button_debouncer_pkg.sv | 17 +
 rtl/button_debouncer_sync_2ff.sv | 25 ++
 rtl/button_debouncer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button front end: FSM state encoding and
// default timing constants (also used by the downstream button counter).
package button_debouncer_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 50000;
   localparam int DEF_HOLD_CYCLES     = 6000000;
   localparam int DEF_REPEAT_CYCLES   = 1200000;
   localparam int DEF_CNT_W           = 24;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pad input, reset to 0.
module button_debouncer_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   // Shift the raw input through two flops; only s2 is used downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises the pad, filters contact bounce with
// a stability counter, and produces a debounced level plus press/release
// strobes, with optional auto-repeat press strobes while the button is held.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = 0,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_active
);

   // Terminal counts; the state changes on reaching them, so counters never wrap.
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic             button_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             pressed_q, pressed_d;
   logic             press_pulse_q, press_pulse_d;
   logic             release_pulse_q, release_pulse_d;
   logic             repeat_active_q, repeat_active_d;

   button_debouncer_sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (button),
      .q   (button_s)
   );

   // Next-state, counters and registered-output values for the debounce FSM.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      hold_cnt_d      = hold_cnt_q;
      pressed_d       = pressed_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      repeat_active_d = repeat_active_q;

      case (state_q)
         ST_RELEASED: begin
            if (button_s) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!button_s) begin
               state_d = ST_RELEASED;
            end else if (cnt_q == DEB_LAST) begin
               state_d         = ST_HELD;
               press_pulse_d   = 1'b1;
               pressed_d       = 1'b1;
               hold_cnt_d      = '0;
               repeat_active_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (!button_s) begin
               state_d         = ST_RELEASE_WAIT;
               cnt_d           = '0;
               hold_cnt_d      = '0;
               repeat_active_d = 1'b0;
            end else if (REPEAT_EN != 0) begin
               // First repeat after the long hold delay, then at the faster rate.
               if (!repeat_active_q && hold_cnt_q == HOLD_LAST) begin
                  press_pulse_d   = 1'b1;
                  repeat_active_d = 1'b1;
                  hold_cnt_d      = '0;
               end else if (repeat_active_q && hold_cnt_q == REP_LAST) begin
                  press_pulse_d = 1'b1;
                  hold_cnt_d    = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
         end
         ST_RELEASE_WAIT: begin
            if (button_s) begin
               // Release bounce: back to held, repeat timing starts over.
               state_d    = ST_HELD;
               hold_cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d         = ST_RELEASED;
               release_pulse_d = 1'b1;
               pressed_d       = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_RELEASED;
         end
      endcase
   end

   // State, counters and outputs; reset overrides everything on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_RELEASED;
         cnt_q           <= '0;
         hold_cnt_q      <= '0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         repeat_active_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         hold_cnt_q      <= hold_cnt_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         repeat_active_q <= repeat_active_d;
      end
   end

   assign pressed       = pressed_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign repeat_active = (REPEAT_EN != 0) ? repeat_active_q : 1'b0;

endmodule
